// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write bus driven by the UART boot loader.
// The master drives one-cycle write strobes; address and data hold between writes.
interface uart_imem_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_we_out;
    logic [ADDR_WIDTH-1:0] imem_addr_out;
    logic [DATA_WIDTH-1:0] imem_wdata_out;

    modport master (
        output imem_we_out,
        output imem_addr_out,
        output imem_wdata_out
    );

    modport slave (
        input imem_we_out,
        input imem_addr_out,
        input imem_wdata_out
    );
endinterface

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives a length-prefixed little-endian image over 8N1 serial,
// writes it word by word into imem, and holds the core in reset until it is complete.
module uart_imem_loader #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_in,
    uart_imem_loader_if.master  imem,
    output logic                cpu_rst_out,
    output logic                load_done_out,
    output logic                err_out,
    output logic [15:0]         words_loaded_out
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   MAX_N  = 17'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_DONE, LD_ERR} ld_state_e;

    // Receiver state
    logic            sync1_q, sync2_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            stop_wait_q, stop_wait_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    // Loader state
    ld_state_e       ld_state_q, ld_state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [23:0]     word_q, word_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
    logic [15:0]     words_loaded_q, words_loaded_d;
    logic            load_done_q, load_done_d;
    logic            err_q, err_d;
    logic            cpu_rst_q, cpu_rst_d;

    logic            rx_s;
    logic            half_tick, bit_tick;
    logic [15:0]     len_n;
    logic [15:0]     idx_inc;
    logic [17:0]     addr_full;

    assign rx_s      = sync2_q;
    assign half_tick = (timer_q == HALF_T);
    assign bit_tick  = (timer_q == LAST_T);
    assign len_n     = {shift_q, len_lo_q};
    assign idx_inc   = idx_q + 16'd1;
    assign addr_full = {idx_q, 2'b00};

    // State register for both FSMs and all datapath flops.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            rx_state_q     <= RX_IDLE;
            timer_q        <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            stop_wait_q    <= 1'b0;
            byte_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            ld_state_q     <= LD_LEN0;
            len_lo_q       <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            lane_q         <= '0;
            word_q         <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            words_loaded_q <= '0;
            load_done_q    <= 1'b0;
            err_q          <= 1'b0;
            cpu_rst_q      <= 1'b1;
        end else begin
            sync1_q        <= rx_in;
            sync2_q        <= sync1_q;
            rx_state_q     <= rx_state_d;
            timer_q        <= timer_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            stop_wait_q    <= stop_wait_d;
            byte_valid_q   <= byte_valid_d;
            frame_err_q    <= frame_err_d;
            ld_state_q     <= ld_state_d;
            len_lo_q       <= len_lo_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            lane_q         <= lane_d;
            word_q         <= word_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            words_loaded_q <= words_loaded_d;
            load_done_q    <= load_done_d;
            err_q          <= err_d;
            cpu_rst_q      <= cpu_rst_d;
        end
    end

    // RX next-state logic.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE:  if (!rx_s) rx_state_d = RX_START;
            RX_START: if (half_tick) rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP: begin
                if (stop_wait_q) begin
                    if (rx_s) rx_state_d = RX_IDLE;
                end else if (bit_tick && rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs and bit-timing datapath.
    always_comb begin
        timer_d      = timer_q + TW'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        stop_wait_d  = stop_wait_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                timer_d     = '0;
                bit_cnt_d   = '0;
                stop_wait_d = 1'b0;
            end
            RX_START: if (half_tick) timer_d = '0;
            RX_DATA: begin
                if (bit_tick) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            RX_STOP: begin
                // A bad stop bit parks here until the line returns high.
                if (stop_wait_q) begin
                    timer_d = '0;
                end else if (bit_tick) begin
                    timer_d = '0;
                    if (rx_s) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        stop_wait_d = 1'b1;
                    end
                end
            end
            default: timer_d = '0;
        endcase
    end

    // Loader next-state logic.
    always_comb begin
        ld_state_d = ld_state_q;
        unique case (ld_state_q)
            LD_LEN0: begin
                if (frame_err_q)       ld_state_d = LD_ERR;
                else if (byte_valid_q) ld_state_d = LD_LEN1;
            end
            LD_LEN1: begin
                if (frame_err_q) begin
                    ld_state_d = LD_ERR;
                end else if (byte_valid_q) begin
                    if (len_n == 16'd0)                 ld_state_d = LD_DONE;
                    else if ({1'b0, len_n} > MAX_N)     ld_state_d = LD_ERR;
                    else                                ld_state_d = LD_DATA;
                end
            end
            LD_DATA: begin
                if (frame_err_q) begin
                    ld_state_d = LD_ERR;
                end else if (byte_valid_q && lane_q == 2'd3 && idx_inc == len_q) begin
                    ld_state_d = LD_DONE;
                end
            end
            LD_DONE: ld_state_d = LD_DONE;
            LD_ERR:  ld_state_d = LD_ERR;
            default: ld_state_d = LD_ERR;
        endcase
    end

    // Loader outputs: word assembly, imem writes and sticky status.
    always_comb begin
        len_lo_d       = len_lo_q;
        len_d          = len_q;
        idx_d          = idx_q;
        lane_d         = lane_q;
        word_d         = word_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        words_loaded_d = words_loaded_q;
        unique case (ld_state_q)
            LD_LEN0: if (byte_valid_q) len_lo_d = shift_q;
            LD_LEN1: begin
                if (byte_valid_q) begin
                    len_d  = len_n;
                    idx_d  = '0;
                    lane_d = '0;
                end
            end
            LD_DATA: begin
                if (byte_valid_q) begin
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: word_d[7:0]   = shift_q;
                        2'd1: word_d[15:8]  = shift_q;
                        2'd2: word_d[23:16] = shift_q;
                        2'd3: begin
                            imem_we_d      = 1'b1;
                            imem_wdata_d   = DATA_WIDTH'({shift_q, word_q});
                            imem_addr_d    = ADDR_WIDTH'(addr_full);
                            words_loaded_d = idx_inc;
                            idx_d          = idx_inc;
                        end
                        default: lane_d = '0;
                    endcase
                end
            end
            default: ;
        endcase

        // An empty image releases the core one cycle after its length byte.
        load_done_d = (ld_state_q == LD_DONE) ||
                      (ld_state_q == LD_LEN1 && byte_valid_q && !frame_err_q && len_n == 16'd0);
        err_d       = (ld_state_d == LD_ERR);
        cpu_rst_d   = !load_done_d;
    end

    assign imem.imem_we_out    = imem_we_q;
    assign imem.imem_addr_out  = imem_addr_q;
    assign imem.imem_wdata_out = imem_wdata_q;
    assign cpu_rst_out         = cpu_rst_q;
    assign load_done_out       = load_done_q;
    assign err_out             = err_q;
    assign words_loaded_out    = words_loaded_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader at 10 clocks per bit and a 4-word image limit.
// Stimulus pushes expected imem writes; a negedge monitor pops and compares each write.
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_in = 1'b1;
    logic        cpu_rst_out, load_done_out, err_out;
    logic [15:0] words_loaded_out;

    uart_imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    uart_imem_loader #(
        .CLK_FREQ(1_000_000), .BAUD(100_000),
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WORDS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .imem(bus),
        .cpu_rst_out(cpu_rst_out), .load_done_out(load_done_out),
        .err_out(err_out), .words_loaded_out(words_loaded_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] words;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  n_writes = 0;
    int  last_we_cyc = -1;
    int  done_cyc    = -1;
    logic done_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.imem_we_out) begin
            n_writes++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.imem_addr_out, mon_e.addr);
                check("wr_data", bus.imem_wdata_out, mon_e.data);
                check("wr_words_loaded", 32'(words_loaded_out), 32'(mon_e.words));
            end
        end
        if (load_done_out && !done_prev) done_cyc = cyc;
        done_prev = load_done_out;
    end

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [15:0] w);
        wr_t e;
        e.addr = a; e.data = d; e.words = w;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rx_in = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (10) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (10) @(negedge clk);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!load_done_out && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(load_done_out), 32'd1);
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w0;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_we", 32'(bus.imem_we_out), 32'd0);
        check("rst_addr", bus.imem_addr_out, 32'd0);
        check("rst_wdata", bus.imem_wdata_out, 32'd0);
        check("rst_words", 32'(words_loaded_out), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst_out), 32'd1);
        check("rst_done", 32'(load_done_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word image
        push_wr(32'h0, 32'h9100_0013, 16'd1);
        push_wr(32'h4, 32'hDEAD_BEEF, 16'd2);
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h91});
        check("t1_cpu_rst_mid", 32'(cpu_rst_out), 32'd1);
        check("t1_done_mid", 32'(load_done_out), 32'd0);
        send_bytes('{8'hEF, 8'hBE, 8'hAD, 8'hDE});
        wait_done("t1_done");
        check("t1_done_latency", 32'(done_cyc - last_we_cyc), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst_out), 32'd0);
        check("t1_words", 32'(words_loaded_out), 32'd2);
        check("t1_addr_hold", bus.imem_addr_out, 32'h4);
        check("t1_wdata_hold", bus.imem_wdata_out, 32'hDEAD_BEEF);
        check("t1_err", 32'(err_out), 32'd0);
        check_drained("t1_pending");

        // Empty image, then bytes and a framing error after DONE are ignored
        do_reset();
        w0 = n_writes;
        send_bytes('{8'h00, 8'h00});
        wait_done("t2_done");
        check("t2_cpu_rst", 32'(cpu_rst_out), 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (5) @(negedge clk);
        check("t2_done_sticky", 32'(load_done_out), 32'd1);
        check("t2_err", 32'(err_out), 32'd0);
        check("t2_words", 32'(words_loaded_out), 32'd0);
        check("t2_no_writes", 32'(n_writes - w0), 32'd0);

        // Start-bit glitch is ignored
        do_reset();
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        push_wr(32'h0, 32'h1234_5678, 16'd1);
        send_bytes('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
        wait_done("t3_done");
        check("t3_words", 32'(words_loaded_out), 32'd1);
        check("t3_err", 32'(err_out), 32'd0);
        check_drained("t3_pending");

        // Framing error in DATA locks into ERR
        do_reset();
        w0 = n_writes;
        send_bytes('{8'h01, 8'h00});
        send_byte(8'hAA, 1'b0);
        check("t4_err", 32'(err_out), 32'd1);
        check("t4_cpu_rst", 32'(cpu_rst_out), 32'd1);
        send_bytes('{8'h11, 8'h22, 8'h33, 8'h44});
        check("t4_err_sticky", 32'(err_out), 32'd1);
        check("t4_done", 32'(load_done_out), 32'd0);
        check("t4_words", 32'(words_loaded_out), 32'd0);
        check("t4_no_writes", 32'(n_writes - w0), 32'd0);

        // Reset mid-word aborts, then a fresh load starts at address 0
        do_reset();
        push_wr(32'h0, 32'h4433_2211, 16'd1);
        send_bytes('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        check_drained("t5_pending_pre");
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("t5_rst_we", 32'(bus.imem_we_out), 32'd0);
        check("t5_rst_addr", bus.imem_addr_out, 32'd0);
        check("t5_rst_wdata", bus.imem_wdata_out, 32'd0);
        check("t5_rst_words", 32'(words_loaded_out), 32'd0);
        check("t5_rst_cpu_rst", 32'(cpu_rst_out), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_wr(32'h0, 32'hDDCC_BBAA, 16'd1);
        send_bytes('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        wait_done("t5_done");
        check("t5_words", 32'(words_loaded_out), 32'd1);
        check_drained("t5_pending");

        // Length overflow
        do_reset();
        w0 = n_writes;
        send_bytes('{8'h05, 8'h00});
        check("t6_err", 32'(err_out), 32'd1);
        check("t6_cpu_rst", 32'(cpu_rst_out), 32'd1);
        send_byte(8'h11, 1'b1);
        check("t6_err_sticky", 32'(err_out), 32'd1);
        check("t6_done", 32'(load_done_out), 32'd0);
        check("t6_no_writes", 32'(n_writes - w0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
